// File: rtl/cpu_pipe_pkg.sv
// rtl/cpu_pipe_pkg.sv - shared widths, field offsets and slot commands for CPU inter-stage registers
package cpu_pipe_pkg;

   localparam int unsigned IF_ID_CTRL_W  = 8;
   localparam int unsigned IF_ID_DATA_W  = 64;
   localparam int unsigned ID_EX_CTRL_W  = 16;
   localparam int unsigned ID_EX_DATA_W  = 138;
   localparam int unsigned EX_MEM_CTRL_W = 16;
   localparam int unsigned EX_MEM_DATA_W = 128;
   localparam int unsigned MEM_WB_CTRL_W = 8;
   localparam int unsigned MEM_WB_DATA_W = 64;

   // Control field layout: all-zero control must decode as a NOP in every stage.
   localparam int unsigned CTRL_ALU_OP_LSB = 0;
   localparam int unsigned CTRL_ALU_OP_W   = 4;
   localparam int unsigned CTRL_MEM_RD_BIT = 4;
   localparam int unsigned CTRL_MEM_WR_BIT = 5;
   localparam int unsigned CTRL_WB_EN_BIT  = 6;
   localparam int unsigned CTRL_RD_LSB     = 7;
   localparam int unsigned CTRL_RD_W       = 5;

   localparam int unsigned DATA_OPA_LSB   = 0;
   localparam int unsigned DATA_OPB_LSB   = 64;
   localparam int unsigned DATA_SHAMT_LSB = 128;
   localparam int unsigned DATA_SHAMT_W   = 6;
   localparam int unsigned DATA_FUNCT_LSB = 134;
   localparam int unsigned DATA_FUNCT_W   = 4;

   localparam logic [ID_EX_CTRL_W-1:0] NOP_CTRL = '0;

   typedef enum logic [1:0] {
      SLOT_HOLD  = 2'd0,
      SLOT_LOAD  = 2'd1,
      SLOT_CLEAR = 2'd2
   } slot_op_e;

endpackage

// File: rtl/pipe_slot.sv
// rtl/pipe_slot.sv - one valid+ctrl+data register with load/clear commands
module pipe_slot
   import cpu_pipe_pkg::*;
#(
   parameter int unsigned CTRL_W    = 16,
   parameter int unsigned DATA_W    = 128,
   parameter bit          ZERO_DATA = 1'b1
) (
   input  logic              clk,
   input  logic              reset,
   input  slot_op_e          op,
   input  logic [CTRL_W-1:0] loadCtrl,
   input  logic [DATA_W-1:0] loadData,
   output logic              valid,
   output logic [CTRL_W-1:0] ctrl,
   output logic [DATA_W-1:0] data
);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         valid <= 1'b0;
         ctrl  <= '0;
         data  <= '0;
      end else begin
         case (op)
            SLOT_LOAD: begin
               valid <= 1'b1;
               ctrl  <= loadCtrl;
               data  <= loadData;
            end
            SLOT_CLEAR: begin
               // Cleared control is the NOP encoding; data may be left stale to save toggles.
               valid <= 1'b0;
               ctrl  <= '0;
               if (ZERO_DATA) data <= '0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - elastic CPU pipeline-stage register with optional skid buffer and flush
module pipe_stage_reg
   import cpu_pipe_pkg::*;
#(
   parameter int unsigned CTRL_W    = 16,
   parameter int unsigned DATA_W    = 128,
   parameter bit          SKID      = 1'b1,
   parameter bit          ZERO_DATA = 1'b1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [CTRL_W-1:0] in_ctrl,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic [DATA_W-1:0] out_data,
   output logic [1:0]        occupancy
);

   logic              inXfer;
   logic              outXfer;
   logic              mainValid;
   logic [CTRL_W-1:0] mainCtrl;
   logic [DATA_W-1:0] mainData;
   slot_op_e          mainOp;
   logic [CTRL_W-1:0] mainLdCtrl;
   logic [DATA_W-1:0] mainLdData;
   logic              mainNextValid;
   logic              readyQ;
   logic              readyNext;
   logic [1:0]        occQ;
   logic [1:0]        occNext;

   assign out_valid     = mainValid;
   assign out_ctrl      = mainCtrl;
   assign out_data      = mainData;
   assign occupancy     = occQ;
   assign inXfer        = in_valid && in_ready;
   assign outXfer       = mainValid && out_ready;
   assign mainNextValid = (mainOp == SLOT_LOAD) || ((mainOp == SLOT_HOLD) && mainValid);

   pipe_slot #(
      .CTRL_W    (CTRL_W),
      .DATA_W    (DATA_W),
      .ZERO_DATA (ZERO_DATA)
   ) u_main (
      .clk      (clk),
      .reset    (reset),
      .op       (mainOp),
      .loadCtrl (mainLdCtrl),
      .loadData (mainLdData),
      .valid    (mainValid),
      .ctrl     (mainCtrl),
      .data     (mainData)
   );

   generate
      if (SKID) begin : g_skid
         slot_op_e          skidOp;
         logic              skidValid;
         logic [CTRL_W-1:0] skidCtrl;
         logic [DATA_W-1:0] skidData;
         logic              skidNextValid;

         pipe_slot #(
            .CTRL_W    (CTRL_W),
            .DATA_W    (DATA_W),
            .ZERO_DATA (ZERO_DATA)
         ) u_skid (
            .clk      (clk),
            .reset    (reset),
            .op       (skidOp),
            .loadCtrl (in_ctrl),
            .loadData (in_data),
            .valid    (skidValid),
            .ctrl     (skidCtrl),
            .data     (skidData)
         );

         // readyQ mirrors !skidValid, so in_ready never depends on out_ready.
         assign in_ready      = readyQ;
         assign skidNextValid = (skidOp == SLOT_LOAD) || ((skidOp == SLOT_HOLD) && skidValid);
         assign readyNext     = !skidNextValid;
         assign occNext       = {1'b0, mainNextValid} + {1'b0, skidNextValid};

         always_comb begin
            mainOp     = SLOT_HOLD;
            skidOp     = SLOT_HOLD;
            mainLdCtrl = in_ctrl;
            mainLdData = in_data;
            if (flush) begin
               mainOp = SLOT_CLEAR;
               skidOp = SLOT_CLEAR;
            end else if (outXfer) begin
               if (skidValid) begin
                  mainOp     = SLOT_LOAD;
                  mainLdCtrl = skidCtrl;
                  mainLdData = skidData;
                  skidOp     = SLOT_CLEAR;
               end else if (inXfer) begin
                  mainOp = SLOT_LOAD;
               end else begin
                  mainOp = SLOT_CLEAR;
               end
            end else if (inXfer) begin
               if (mainValid) skidOp = SLOT_LOAD;
               else           mainOp = SLOT_LOAD;
            end
         end
      end else begin : g_single
         // readyQ only masks in_ready during reset and the first edge after release.
         assign in_ready   = readyQ && (out_ready || !mainValid);
         assign readyNext  = 1'b1;
         assign occNext    = {1'b0, mainNextValid};
         assign mainLdCtrl = in_ctrl;
         assign mainLdData = in_data;

         always_comb begin
            mainOp = SLOT_HOLD;
            if (flush)        mainOp = SLOT_CLEAR;
            else if (inXfer)  mainOp = SLOT_LOAD;
            else if (outXfer) mainOp = SLOT_CLEAR;
         end
      end
   endgenerate

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         readyQ <= 1'b0;
         occQ   <= 2'd0;
      end else begin
         readyQ <= readyNext;
         occQ   <= occNext;
      end
   end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb/tb_pipe_stage_reg.sv - directed vector bench for pipe_stage_reg in skid and single-register forms
module tb_pipe_stage_reg;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic reset;

   logic        aFlush, aInValid, aInReady, aOutValid, aOutReady;
   logic [15:0] aInCtrl, aOutCtrl;
   logic [31:0] aInData, aOutData;
   logic [1:0]  aOcc;

   logic        bFlush, bInValid, bInReady, bOutValid, bOutReady;
   logic [15:0] bInCtrl, bOutCtrl;
   logic [31:0] bInData, bOutData;
   logic [1:0]  bOcc;

   pipe_stage_reg #(.CTRL_W(16), .DATA_W(32), .SKID(1'b1), .ZERO_DATA(1'b1)) u_dutA (
      .clk(clk), .reset(reset), .flush(aFlush),
      .in_valid(aInValid), .in_ready(aInReady), .in_ctrl(aInCtrl), .in_data(aInData),
      .out_valid(aOutValid), .out_ready(aOutReady), .out_ctrl(aOutCtrl), .out_data(aOutData),
      .occupancy(aOcc)
   );

   pipe_stage_reg #(.CTRL_W(16), .DATA_W(32), .SKID(1'b0), .ZERO_DATA(1'b0)) u_dutB (
      .clk(clk), .reset(reset), .flush(bFlush),
      .in_valid(bInValid), .in_ready(bInReady), .in_ctrl(bInCtrl), .in_data(bInData),
      .out_valid(bOutValid), .out_ready(bOutReady), .out_ctrl(bOutCtrl), .out_data(bOutData),
      .occupancy(bOcc)
   );

   typedef struct {
      logic        fl;
      logic        iv;
      logic [15:0] ic;
      logic [31:0] id;
      logic        ordy;
      logic        ov;
      logic [15:0] oc;
      logic [31:0] od;
      logic [1:0]  occ;
      logic        ir;
   } vec_t;

   vec_t tbl[$];
   int   nApplied = 0;
   int   nMiss    = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      nApplied++;
      if (act !== exp) begin
         nMiss++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic fl, input logic iv, input logic [15:0] ic,
                               input logic [31:0] id, input logic ordy, input logic ov,
                               input logic [15:0] oc, input logic [31:0] od,
                               input logic [1:0] occ, input logic ir);
      vec_t v;
      v.fl = fl; v.iv = iv; v.ic = ic; v.id = id; v.ordy = ordy;
      v.ov = ov; v.oc = oc; v.od = od; v.occ = occ; v.ir = ir;
      return v;
   endfunction

   task automatic checkA(input string tag, input logic ov, input logic [15:0] oc,
                         input logic [31:0] od, input logic [1:0] occ, input logic ir);
      chk({tag, " out_valid"}, 32'(aOutValid), 32'(ov));
      chk({tag, " out_ctrl"},  32'(aOutCtrl),  32'(oc));
      chk({tag, " out_data"},  aOutData,       od);
      chk({tag, " occupancy"}, 32'(aOcc),      32'(occ));
      chk({tag, " in_ready"},  32'(aInReady),  32'(ir));
   endtask

   task automatic checkB(input string tag, input logic ov, input logic [15:0] oc,
                         input logic [31:0] od, input logic [1:0] occ, input logic ir);
      chk({tag, " out_valid"}, 32'(bOutValid), 32'(ov));
      chk({tag, " out_ctrl"},  32'(bOutCtrl),  32'(oc));
      chk({tag, " out_data"},  bOutData,       od);
      chk({tag, " occupancy"}, 32'(bOcc),      32'(occ));
      chk({tag, " in_ready"},  32'(bInReady),  32'(ir));
   endtask

   task automatic stepB(input logic fl, input logic iv, input logic [15:0] ic,
                        input logic [31:0] id, input logic ordy);
      bFlush = fl; bInValid = iv; bInCtrl = ic; bInData = id; bOutReady = ordy;
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 1'b0;
      aFlush = 0; aInValid = 0; aInCtrl = '0; aInData = '0; aOutReady = 0;
      bFlush = 0; bInValid = 0; bInCtrl = '0; bInData = '0; bOutReady = 0;

      // Each row: inputs applied before an edge, outputs expected just after it.
      tbl.push_back(mk(0, 0, 16'h0000, 32'h0,    1, 0, 16'h0000, 32'h0,    2'd0, 1));
      tbl.push_back(mk(0, 1, 16'h00A5, 32'h1234, 1, 1, 16'h00A5, 32'h1234, 2'd1, 1));
      for (int k = 1; k <= 8; k++)
         tbl.push_back(mk(0, 1, 16'(k), 32'h100 + 32'(k), 1, 1, 16'(k), 32'h100 + 32'(k), 2'd1, 1));
      tbl.push_back(mk(0, 0, 16'h0000, 32'h0,    1, 0, 16'h0000, 32'h0,    2'd0, 1));
      tbl.push_back(mk(0, 1, 16'h0003, 32'h33,   0, 1, 16'h0003, 32'h33,   2'd1, 1));
      tbl.push_back(mk(0, 1, 16'h0004, 32'h44,   0, 1, 16'h0003, 32'h33,   2'd2, 0));
      tbl.push_back(mk(0, 1, 16'h0005, 32'h55,   0, 1, 16'h0003, 32'h33,   2'd2, 0));
      tbl.push_back(mk(0, 1, 16'h0005, 32'h55,   1, 1, 16'h0004, 32'h44,   2'd1, 1));
      tbl.push_back(mk(0, 1, 16'h0005, 32'h55,   1, 1, 16'h0005, 32'h55,   2'd1, 1));
      tbl.push_back(mk(0, 0, 16'h0000, 32'h0,    1, 0, 16'h0000, 32'h0,    2'd0, 1));
      tbl.push_back(mk(0, 1, 16'h0011, 32'h1111, 0, 1, 16'h0011, 32'h1111, 2'd1, 1));
      tbl.push_back(mk(0, 1, 16'h0012, 32'h1212, 0, 1, 16'h0011, 32'h1111, 2'd2, 0));
      tbl.push_back(mk(1, 1, 16'h0009, 32'h9999, 0, 0, 16'h0000, 32'h0,    2'd0, 1));
      tbl.push_back(mk(0, 0, 16'h0000, 32'h0,    0, 0, 16'h0000, 32'h0,    2'd0, 1));
      tbl.push_back(mk(0, 1, 16'h0021, 32'h2121, 1, 1, 16'h0021, 32'h2121, 2'd1, 1));
      tbl.push_back(mk(1, 1, 16'h0022, 32'h2222, 1, 0, 16'h0000, 32'h0,    2'd0, 1));
      tbl.push_back(mk(0, 0, 16'h0000, 32'h0,    1, 0, 16'h0000, 32'h0,    2'd0, 1));

      #12;
      checkA("rstA", 0, 16'h0, 32'h0, 2'd0, 0);
      checkB("rstB", 0, 16'h0, 32'h0, 2'd0, 0);

      @(negedge clk);
      reset = 1'b1;

      for (int i = 0; i < tbl.size(); i++) begin
         aFlush = tbl[i].fl; aInValid = tbl[i].iv; aInCtrl = tbl[i].ic;
         aInData = tbl[i].id; aOutReady = tbl[i].ordy;
         @(posedge clk);
         #1;
         checkA($sformatf("vec%0d", i), tbl[i].ov, tbl[i].oc, tbl[i].od, tbl[i].occ, tbl[i].ir);
      end

      // Asynchronous reset with both slots full must clear outputs before any edge.
      aFlush = 0; aOutReady = 0; aInValid = 1; aInCtrl = 16'h0031; aInData = 32'h3131;
      @(posedge clk);
      #1;
      aInCtrl = 16'h0032; aInData = 32'h3232;
      @(posedge clk);
      #1;
      chk("preRst occupancy", 32'(aOcc), 32'd2);
      aInValid = 0;
      #2;
      reset = 1'b0;
      #1;
      checkA("asyncRst", 0, 16'h0, 32'h0, 2'd0, 0);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
      checkA("postRst", 0, 16'h0, 32'h0, 2'd0, 1);

      // Single-register stage without data zeroing.
      stepB(0, 1, 16'h0007, 32'hBEEF, 0);
      checkB("b7full", 1, 16'h0007, 32'hBEEF, 2'd1, 0);
      bInValid = 0; bOutReady = 1;
      #1;
      chk("b7 combReady", 32'(bInReady), 32'd1);
      stepB(0, 0, 16'h0000, 32'h0, 1);
      checkB("b7pop", 0, 16'h0000, 32'hBEEF, 2'd0, 1);
      stepB(0, 1, 16'h0001, 32'h0011, 1);
      checkB("bS1", 1, 16'h0001, 32'h0011, 2'd1, 1);
      stepB(0, 1, 16'h0002, 32'h0022, 1);
      checkB("bS2", 1, 16'h0002, 32'h0022, 2'd1, 1);
      stepB(0, 1, 16'h0005, 32'h0055, 1);
      checkB("bS5", 1, 16'h0005, 32'h0055, 2'd1, 1);
      stepB(1, 1, 16'h0006, 32'h0066, 1);
      checkB("bFlush", 0, 16'h0000, 32'h0055, 2'd0, 1);
      stepB(0, 0, 16'h0000, 32'h0, 1);
      checkB("bIdle", 0, 16'h0000, 32'h0055, 2'd0, 1);

      $display("== %0d vectors applied, %0d miscompares ==", nApplied, nMiss);
      $finish;
   end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
Parametrised elastic pipeline-stage register that generalises our fixed inter-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB) into one block.
- Carries a control field and a data field, each of configurable width, under a valid/ready handshake.
- Optional 2-entry skid buffer cuts the combinational ready path.
- Synchronous flush zeroes held entries so they become bubbles; an empty stage always presents zero control, which makes it a NOP downstream.
- Placed between any two CPU pipeline stages; the hazard unit drives flush, and downstream back-pressure replaces the old stall input.

Parameters:
- CTRL_W, 16, width of control payload (ALU code, mem/WB enables, register addresses).
- DATA_W, 128, width of data payload (operands, immediates, shift amount).
- SKID, 1: 1 = two-entry skid buffer with registered in_ready; 0 = single register with combinational in_ready.
- ZERO_DATA, 1: 1 = data field is also cleared on flush/drain; 0 = data field holds its last value and only control is cleared.

Ports:
- clk, in, 1, rising-edge clock.
- reset, in, 1, asynchronous, active-low reset.
- flush, in, 1, synchronous kill of all held entries and of the current input transfer.
- in_valid, in, 1, upstream entry valid.
- in_ready, out, 1, stage can accept an entry this cycle.
- in_ctrl, in, CTRL_W, upstream control payload.
- in_data, in, DATA_W, upstream data payload.
- out_valid, out, 1, entry presented downstream.
- out_ready, in, 1, downstream accepts this cycle.
- out_ctrl, out, CTRL_W, control payload presented downstream.
- out_data, out, DATA_W, data payload presented downstream.
- occupancy, out, 2, number of held entries: 0..2 when SKID=1, 0..1 when SKID=0.

Behaviour:
- Transfers: an input transfer occurs when in_valid && in_ready; an output transfer occurs when out_valid && out_ready.
- Reset (reset=0, asynchronous): all entries invalid; out_valid=0, out_ctrl=0, out_data=0, occupancy=0, in_ready=0 while in reset.
  - First edge after reset release: in_ready=1.
- Latency and throughput: 1 cycle from input transfer to out_valid=1; sustains 1 transfer per cycle when out_ready is held at 1.
- Ordering: FIFO order is strictly preserved; no entry is ever duplicated or dropped except by flush.
- SKID=0:
  - Single register; in_ready = out_ready || !out_valid (combinational).
  - Load on input transfer.
  - On an output transfer without a simultaneous input transfer: valid<=0, and ctrl<=0 (data<=0 if ZERO_DATA).
- SKID=1 uses two registers: main, which drives the outputs, and skid.
  - in_ready = !skid_valid, taken from a register with no path from out_ready.
  - Input transfer while main is empty, or while main is being popped with skid empty: the entry goes to main.
  - Input transfer while main is valid and not being popped: the entry goes to skid.
  - Output transfer with skid valid: main<=skid, skid is cleared (ctrl<=0, data<=0 if ZERO_DATA).
  - Skid full (occupancy=2): in_ready=0 on the next cycle; upstream must hold in_valid and its payload stable.
- Empty outputs: whenever out_valid=0, out_ctrl==0 is guaranteed; out_data==0 also when ZERO_DATA=1.
- Flush:
  - Sampled at the clock edge; on that edge all entries are cleared (valid=0, ctrl=0, data per ZERO_DATA) and occupancy=0.
  - An input transfer in the same cycle is discarded.
  - The output handshake in the flush cycle is still a valid transfer to the downstream.
  - in_ready is 1 in the cycle after a flush.
- Simultaneous input and output transfer at occupancy=1: occupancy stays 1; main takes the new entry (SKID=1 routes it to main, not skid).
- Reset mid-operation: all entries are lost immediately and asynchronously; there is no recovery of in-flight data.
- occupancy is registered and matches valid bits exactly.

Decomposition:
- Shared package cpu_pipe_pkg:
  - localparam widths for each stage's ctrl/data bundles (e.g. ID_EX_CTRL_W=16, ID_EX_DATA_W=138).
  - Pack/unpack field offsets.
  - A NOP_CTRL constant of all zeros.
- One natural sub-module: pipe_slot, a single valid+ctrl+data register with load/clear. It is instantiated once for SKID=0 and twice (main, skid) for SKID=1.

Test Plan:
- Reset release, then in_valid=1 with ctrl=0x00A5, data=0x1234 and out_ready=1 -> one cycle later out_valid=1, out_ctrl=0x00A5, out_data=0x1234, occupancy=1.
- Streaming 8 entries ctrl=1..8 with out_ready=1 every cycle -> outputs 1..8 on consecutive cycles, in_ready stays 1, no gaps.
- SKID=1, out_ready=0 while pushing ctrl=3,4,5 -> 3 in main, 4 in skid, occupancy=2, in_ready=0, entry 5 held upstream. Then out_ready=1 -> 3,4,5 emitted in order over 3 cycles.
- Flush at occupancy=2 with in_valid=1 (ctrl=9) -> next cycle out_valid=0, out_ctrl=0, out_data=0, occupancy=0; ctrl=9 never appears at the output.
- ZERO_DATA=0, SKID=0: entry ctrl=7, data=0xBEEF popped with no refill -> out_valid=0, out_ctrl=0, out_data stays 0xBEEF.
- Assert reset=0 asynchronously mid-cycle at occupancy=2 -> outputs zero immediately, before the next clk edge; occupancy=0 after release.
